// File: rtl/axi_sram_responder.sv
// rtl/axi_sram_responder.sv - AXI4 slave answering AW/W/AR with B/R from an internal word-addressed SRAM (optional AXI_SRAM_ERRCNT_EN adds err_cnt_o)
module axi_sram_responder #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 16,
    parameter int AXI_USER_WIDTH = 1,
    parameter int MEM_WORDS      = 1024,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    // write address channel
    input  logic                        aw_valid,
    output logic                        aw_ready,
    input  logic [AXI_ID_WIDTH-1:0]     aw_id,
    input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr,
    input  logic [7:0]                  aw_len,
    input  logic [2:0]                  aw_size,
    input  logic [1:0]                  aw_burst,
    // write data channel
    input  logic                        w_valid,
    output logic                        w_ready,
    input  logic [AXI_DATA_WIDTH-1:0]   w_data,
    input  logic [AXI_DATA_WIDTH/8-1:0] w_strb,
    input  logic                        w_last,
    // write response channel
    output logic                        b_valid,
    input  logic                        b_ready,
    output logic [AXI_ID_WIDTH-1:0]     b_id,
    output logic [1:0]                  b_resp,
    output logic [AXI_USER_WIDTH-1:0]   b_user,
    // read address channel
    input  logic                        ar_valid,
    output logic                        ar_ready,
    input  logic [AXI_ID_WIDTH-1:0]     ar_id,
    input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr,
    input  logic [7:0]                  ar_len,
    input  logic [2:0]                  ar_size,
    input  logic [1:0]                  ar_burst,
    // read data channel
    output logic                        r_valid,
    input  logic                        r_ready,
    output logic [AXI_ID_WIDTH-1:0]     r_id,
    output logic [AXI_DATA_WIDTH-1:0]   r_data,
    output logic [1:0]                  r_resp,
    output logic                        r_last,
    output logic [AXI_USER_WIDTH-1:0]   r_user
`ifdef AXI_SRAM_ERRCNT_EN
    ,
    output logic [15:0]                 err_cnt_o
`endif
);

    localparam int NB     = AXI_DATA_WIDTH / 8;
    localparam int LOG_NB = $clog2(NB);
    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam int AW     = AXI_ADDR_WIDTH;
    localparam logic [AW:0] MEM_BYTES = (AW+1)'(MEM_WORDS * NB);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    // A beat is served only if it lands inside the SRAM window with a
    // supported size and a FIXED/INCR burst; the extra top bit of the
    // difference is the borrow that flags addresses below BASE_ADDR.
    function automatic logic beat_legal(input logic [AW-1:0] addr,
                                        input logic [2:0]    size,
                                        input logic [1:0]    burst);
        logic [AW:0] diff;
        diff = {1'b0, addr} - {1'b0, BASE_ADDR};
        return !diff[AW] && (diff < MEM_BYTES) && (size <= 3'(LOG_NB)) &&
               ((burst == BURST_FIXED) || (burst == BURST_INCR));
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [AW-1:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> LOG_NB);
    endfunction

    // INCR aligns to the transfer size then steps; FIXED stays put.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr,
                                                input logic [2:0]    size,
                                                input logic [1:0]    burst);
        logic [AW-1:0] step;
        step = AW'(1) << size;
        if (burst == BURST_FIXED) begin
            return addr;
        end
        return (addr & ~(step - AW'(1))) + step;
    endfunction

    logic [AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic     run_q;
    w_state_t w_state, w_state_nxt;
    r_state_t r_state, r_state_nxt;

    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_len;
    logic [7:0]    wr_beat;
    logic [2:0]    wr_size;
    logic [1:0]    wr_burst;
    logic          wr_err;

    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_len;
    logic [7:0]    rd_beat;
    logic [2:0]    rd_size;
    logic [1:0]    rd_burst;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic wr_legal, wr_is_last, wr_err_nxt;
    logic [AW-1:0] ld_addr;
    logic [2:0]    ld_size;
    logic [1:0]    ld_burst;
    logic          ld_legal;
    logic          rd_load;

    assign aw_hs = aw_valid & aw_ready;
    assign w_hs  = w_valid  & w_ready;
    assign b_hs  = b_valid  & b_ready;
    assign ar_hs = ar_valid & ar_ready;
    assign r_hs  = r_valid  & r_ready;

    assign b_user = '0;
    assign r_user = '0;

    assign wr_legal   = beat_legal(wr_addr, wr_size, wr_burst);
    assign wr_is_last = (wr_beat == wr_len);
    assign wr_err_nxt = wr_err | ~wr_legal | (w_last != wr_is_last);

    // Hold every ready low while in reset and release them one cycle after.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // Write engine state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_state_nxt;
        end
    end

    // Write engine next state and channel handshake outputs.
    always_comb begin
        w_state_nxt = w_state;
        aw_ready    = 1'b0;
        w_ready     = 1'b0;
        b_valid     = 1'b0;
        case (w_state)
            W_IDLE: begin
                aw_ready = run_q;
                if (aw_valid && run_q) begin
                    w_state_nxt = W_DATA;
                end
            end
            W_DATA: begin
                w_ready = 1'b1;
                if (w_valid && wr_is_last) begin
                    w_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                b_valid = 1'b1;
                if (b_ready) begin
                    w_state_nxt = W_IDLE;
                end
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Latch the write burst, step the address per beat, build B response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_addr  <= '0;
            wr_len   <= '0;
            wr_beat  <= '0;
            wr_size  <= '0;
            wr_burst <= '0;
            wr_err   <= 1'b0;
            b_id     <= '0;
            b_resp   <= RESP_OKAY;
        end else if (aw_hs) begin
            wr_addr  <= aw_addr;
            wr_len   <= aw_len;
            wr_beat  <= '0;
            wr_size  <= aw_size;
            wr_burst <= aw_burst;
            wr_err   <= 1'b0;
            b_id     <= aw_id;
            b_resp   <= RESP_OKAY;
        end else if (w_hs) begin
            wr_addr <= next_addr(wr_addr, wr_size, wr_burst);
            wr_beat <= wr_beat + 8'd1;
            wr_err  <= wr_err_nxt;
            if (wr_is_last) begin
                b_resp <= wr_err_nxt ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // SRAM byte-lane write; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (w_hs && wr_legal && !rst_i) begin
            for (int b = 0; b < NB; b++) begin
                if (w_strb[b]) begin
                    mem[word_idx(wr_addr)][8*b +: 8] <= w_data[8*b +: 8];
                end
            end
        end
    end

    // Read engine state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_state_nxt;
        end
    end

    // Read engine next state and channel handshake outputs.
    always_comb begin
        r_state_nxt = r_state;
        ar_ready    = 1'b0;
        r_valid     = 1'b0;
        case (r_state)
            R_IDLE: begin
                ar_ready = run_q;
                if (ar_valid && run_q) begin
                    r_state_nxt = R_DATA;
                end
            end
            R_DATA: begin
                r_valid = 1'b1;
                if (r_ready && r_last) begin
                    r_state_nxt = R_IDLE;
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // Address of the beat to fetch next: the AR address on acceptance,
    // otherwise the successor of the beat being handed over.
    always_comb begin
        ld_addr  = next_addr(rd_addr, rd_size, rd_burst);
        ld_size  = rd_size;
        ld_burst = rd_burst;
        if (r_state == R_IDLE) begin
            ld_addr  = ar_addr;
            ld_size  = ar_size;
            ld_burst = ar_burst;
        end
        ld_legal = beat_legal(ld_addr, ld_size, ld_burst);
        rd_load  = ar_hs | (r_hs & ~r_last);
    end

    // Registered SRAM read; a non-blocking read alongside the write block
    // returns the old word on a same-cycle write (read-first).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_addr  <= '0;
            rd_len   <= '0;
            rd_beat  <= '0;
            rd_size  <= '0;
            rd_burst <= '0;
            r_id     <= '0;
            r_data   <= '0;
            r_resp   <= RESP_OKAY;
            r_last   <= 1'b0;
        end else if (rd_load) begin
            rd_addr <= ld_addr;
            r_data  <= ld_legal ? mem[word_idx(ld_addr)] : '0;
            r_resp  <= ld_legal ? RESP_OKAY : RESP_SLVERR;
            if (ar_hs) begin
                rd_len   <= ar_len;
                rd_beat  <= '0;
                rd_size  <= ar_size;
                rd_burst <= ar_burst;
                r_id     <= ar_id;
                r_last   <= (ar_len == 8'd0);
            end else begin
                rd_beat <= rd_beat + 8'd1;
                r_last  <= ((rd_beat + 8'd1) == rd_len);
            end
        end
    end

`ifdef AXI_SRAM_ERRCNT_EN
    logic        b_err_hs;
    logic        r_err_hs;
    logic [16:0] err_sum;

    assign b_err_hs = b_hs & (b_resp == RESP_SLVERR);
    assign r_err_hs = r_hs & (r_resp == RESP_SLVERR);
    assign err_sum  = {1'b0, err_cnt_o} + 17'(b_err_hs) + 17'(r_err_hs);

    // Saturating count of SLVERR responses actually handed over.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_cnt_o <= '0;
        end else if (err_sum > 17'h0FFFF) begin
            err_cnt_o <= 16'hFFFF;
        end else begin
            err_cnt_o <= err_sum[15:0];
        end
    end
`endif

endmodule
